// File: rtl/ex_pkg.sv
// Shared constants for the MIPS execute stage: ALUOp/funct encodings, ALU-control codes, control-bus bit indices, multiplier FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: aluop codes, funct constants, alu_ctl_e (4-bit), EX control bit indices, mul_state_e,
//           alu_ctl_decode() which maps {aluop, funct} to an ALU operation.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq compare
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R-type, decode funct
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;  // treated as add

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_MUL = 4'b1000,
    ALU_NOP = 4'b1111   // result forced to 0
  } alu_ctl_e;

  // ex_in = {regdst, aluop[1:0], alusrc}
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_MSB = 2;
  localparam int EX_ALUOP_LSB = 1;
  localparam int EX_ALUSRC    = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  function automatic alu_ctl_e alu_ctl_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_ctl_e ctl;
    ctl = ALU_NOP;
    case (aluop)
      ALUOP_ADD, ALUOP_ADD2: ctl = ALU_ADD;
      ALUOP_SUB:             ctl = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD:  ctl = ALU_ADD;
          FUNCT_SUB:  ctl = ALU_SUB;
          FUNCT_AND:  ctl = ALU_AND;
          FUNCT_OR:   ctl = ALU_OR;
          FUNCT_SLT:  ctl = ALU_SLT;
          FUNCT_MULT: ctl = ALU_MUL;
          default:    ctl = ALU_NOP;
        endcase
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// Sequential shift-add multiplier, low DW bits of a*b (unsigned), one partial product per cycle.
// Latency: 1 load cycle + MUL_CYC busy cycles, product valid while done=1.
// Backpressure: stall is high (combinationally on start) until the DONE cycle; start ignored outside IDLE.
// Ports: clk, rst (async, active-high), start (op decoded), a/b operands,
//        stall (freeze front end), done (product valid this cycle), product.
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MUL_CYC = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] product
);

  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  mul_state_e    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [DW-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(MUL_CYC - 1)) state <= MUL_DONE;
        end
        // One cycle only: the held instruction advances on this edge, so it
        // can never be re-started by the same start request.
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign stall   = (state == MUL_BUSY) || ((state == MUL_IDLE) && start);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control, 32-bit ALU, ALUSrc/RegDst muxes, branch-target adder, EX/MEM latch.
// Latency: 1 cycle into EX/MEM; a MULT takes 34 cycles (stall high for 33).
// Backpressure: none unless MULT_EN; then stall freezes the front end and the latch loads bubbles.
// Config macro: MULT_EN (defined -> ex_mul_seq hosted for funct 011000; undefined -> stall tied 0, mult yields 0).
// Ports in : clk, rst (async, active-high), wb_in{regwrite,memtoreg}, mem_in{branch,memread,memwrite},
//            ex_in{regdst,aluop[1:0],alusrc}, npc, readdat1 (rs), readdat2 (rt), sign_ext ([5:0]=funct), rt, rd.
// Ports out: wb_out, mem_out, branch_target, zero, alu_result, wdata_out, dest_reg (all registered), stall (comb).
module ex_stage
  import ex_pkg::*;
#(
  parameter int DW = 32
`ifdef MULT_EN
  ,
  parameter int MUL_CYC = 32
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    wb_in,
  input  logic [2:0]    mem_in,
  input  logic [3:0]    ex_in,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] readdat1,
  input  logic [DW-1:0] readdat2,
  input  logic [DW-1:0] sign_ext,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  output logic [1:0]    wb_out,
  output logic [2:0]    mem_out,
  output logic [DW-1:0] branch_target,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] wdata_out,
  output logic [4:0]    dest_reg,
  output logic          stall
);

  logic [1:0]    aluop;
  logic [DW-1:0] opb;
  alu_ctl_e      alu_ctl;
  logic [DW-1:0] mul_res;
  logic [DW-1:0] alu_next;
  logic [DW-1:0] bt_next;
  logic [4:0]    dest_next;

  assign aluop     = ex_in[EX_ALUOP_MSB:EX_ALUOP_LSB];
  assign opb       = ex_in[EX_ALUSRC] ? sign_ext : readdat2;
  assign alu_ctl   = alu_ctl_decode(aluop, sign_ext[5:0]);
  assign bt_next   = npc + (sign_ext << 2);
  assign dest_next = ex_in[EX_REGDST] ? rd : rt;

`ifdef MULT_EN
  logic          mul_start;
  logic          mul_done;
  logic [DW-1:0] mul_product;

  // Gated by rst so stall reads 0 during reset even if a MULT is still presented.
  assign mul_start = !rst && (alu_ctl == ALU_MUL);

  ex_mul_seq #(
    .DW      (DW),
    .MUL_CYC (MUL_CYC)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (readdat1),
    .b       (readdat2),
    .stall   (stall),
    .done    (mul_done),
    .product (mul_product)
  );

  // Only the DONE cycle reaches the latch (stall blocks the others).
  assign mul_res = mul_done ? mul_product : '0;
`else
  assign stall   = 1'b0;
  assign mul_res = '0;
`endif

  always_comb begin
    alu_next = '0;
    case (alu_ctl)
      ALU_ADD: alu_next = readdat1 + opb;
      ALU_SUB: alu_next = readdat1 - opb;
      ALU_AND: alu_next = readdat1 & opb;
      ALU_OR:  alu_next = readdat1 | opb;
      ALU_SLT: alu_next = {{(DW-1){1'b0}}, ($signed(readdat1) < $signed(opb))};
      ALU_MUL: alu_next = mul_res;
      default: alu_next = '0;
    endcase
  end

  // EX/MEM latch. While stalled only the control fields are squashed;
  // datapath fields hold so the bubble carries no side effects downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_out        <= '0;
      mem_out       <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      wdata_out     <= '0;
      dest_reg      <= '0;
    end else if (stall) begin
      wb_out  <= '0;
      mem_out <= '0;
    end else begin
      wb_out        <= wb_in;
      mem_out       <= mem_in;
      branch_target <= bt_next;
      zero          <= (alu_next == '0);
      alu_result    <= alu_next;
      wdata_out     <= readdat2;
      dest_reg      <= dest_next;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_in;
  logic [2:0]  mem_in;
  logic [3:0]  ex_in;
  logic [31:0] npc, readdat1, readdat2, sign_ext;
  logic [4:0]  rt, rd;
  logic [1:0]  wb_out;
  logic [2:0]  mem_out;
  logic [31:0] branch_target, alu_result, wdata_out;
  logic        zero, stall;
  logic [4:0]  dest_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in),
    .npc(npc), .readdat1(readdat1), .readdat2(readdat2), .sign_ext(sign_ext),
    .rt(rt), .rd(rd), .wb_out(wb_out), .mem_out(mem_out),
    .branch_target(branch_target), .zero(zero), .alu_result(alu_result),
    .wdata_out(wdata_out), .dest_reg(dest_reg), .stall(stall)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] rs;
    logic [31:0] rtv;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] exp_alu;
    logic        exp_zero;
    logic [4:0]  exp_dest;
    logic [31:0] exp_bt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                              input logic [31:0] n, input logic [31:0] rs, input logic [31:0] rtv,
                              input logic [31:0] imm, input logic [4:0] rtf, input logic [4:0] rdf,
                              input logic [31:0] ealu, input logic ez, input logic [4:0] ed,
                              input logic [31:0] ebt);
    vec_t v;
    v.wb = wb; v.mem = mem; v.ex = ex; v.npc = n; v.rs = rs; v.rtv = rtv; v.imm = imm;
    v.rt = rtf; v.rd = rdf; v.exp_alu = ealu; v.exp_zero = ez; v.exp_dest = ed; v.exp_bt = ebt;
    return v;
  endfunction

  // Reference: instruction semantics in plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [1:0] aluop, input logic [5:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    if (aluop == 2'b00 || aluop == 2'b11) return a + b;
    if (aluop == 2'b01) return a - b;
    case (f)
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd42:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;   // includes mult when no multiplier is built
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb_in = v.wb; mem_in = v.mem; ex_in = v.ex; npc = v.npc;
    readdat1 = v.rs; readdat2 = v.rtv; sign_ext = v.imm; rt = v.rt; rd = v.rd;
  endtask

  task automatic apply_check(input string tag, input vec_t v);
    drive(v);
    @(posedge clk); #1;
    check({tag, " alu_result"}, alu_result, v.exp_alu);
    check({tag, " zero"}, {31'd0, zero}, {31'd0, v.exp_zero});
    check({tag, " dest_reg"}, {27'd0, dest_reg}, {27'd0, v.exp_dest});
    check({tag, " branch_target"}, branch_target, v.exp_bt);
    check({tag, " wb_out"}, {30'd0, wb_out}, {30'd0, v.wb});
    check({tag, " mem_out"}, {29'd0, mem_out}, {29'd0, v.mem});
    check({tag, " wdata_out"}, wdata_out, v.rtv);
    check({tag, " stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wb_out"}, {30'd0, wb_out}, 32'd0);
    check({tag, " mem_out"}, {29'd0, mem_out}, 32'd0);
    check({tag, " branch_target"}, branch_target, 32'd0);
    check({tag, " zero"}, {31'd0, zero}, 32'd0);
    check({tag, " alu_result"}, alu_result, 32'd0);
    check({tag, " wdata_out"}, wdata_out, 32'd0);
    check({tag, " dest_reg"}, {27'd0, dest_reg}, 32'd0);
    check({tag, " stall"}, {31'd0, stall}, 32'd0);
  endtask

`ifdef MULT_EN
  // Call in cycle 0 of a MULT (inputs already presented). Counts stall cycles,
  // verifies bubbles, then the product on the edge ending DONE.
  task automatic run_mult(input string tag, input logic [31:0] exp_prod,
                          input logic [1:0] exp_wb, input logic [4:0] exp_dest);
    int  stall_cycles;
    bit  seen_done;
    bit  bubble_bad;
    logic s;
    stall_cycles = 0; seen_done = 0; bubble_bad = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      s = stall;
      @(posedge clk); #1;
      if (s) begin
        stall_cycles++;
        if (wb_out !== 2'b00 || mem_out !== 3'b000) bubble_bad = 1;
      end else begin
        seen_done = 1;
      end
    end
    check({tag, " reached done"}, {31'd0, seen_done}, 32'd1);
    check({tag, " stall cycles"}, stall_cycles, 32'd33);
    check({tag, " bubbles"}, {31'd0, bubble_bad}, 32'd0);
    check({tag, " product"}, alu_result, exp_prod);
    check({tag, " wb after"}, {30'd0, wb_out}, {30'd0, exp_wb});
    check({tag, " dest after"}, {27'd0, dest_reg}, {27'd0, exp_dest});
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [5:0] fl [8];
    logic [5:0] f;

    // ---------------- directed table ----------------
    //              wb     mem     ex       npc           rs            rt-val        imm           rt  rd   alu           z  dest bt
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h200, 32'd7,        32'd5,        32'h20,       5'd3, 5'd9, 32'd12,       0, 5'd9, 32'h280));
    tbl.push_back(mk(2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234,     32'h1234,     32'd3,        5'd2, 5'd6, 32'd0,        1, 5'd2, 32'h10C));
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'hFFFFFFFF, 32'd1,        32'h2A,       5'd1, 5'd4, 32'd1,        0, 5'd4, 32'hA8));
    tbl.push_back(mk(2'b11, 3'b010, 4'b0001, 32'h40,  32'h1000,     32'h55,       32'hFFFFFFFC, 5'd8, 5'd12,32'h0FFC,     0, 5'd8, 32'h30));
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h10,  32'hFFFFFFFF, 32'd1,        32'h20,       5'd1, 5'd5, 32'd0,        1, 5'd5, 32'h90));
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd5,        32'd3,        32'h07,       5'd1, 5'd6, 32'd0,        1, 5'd6, 32'h1C));
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'hF0F0,     32'hFF00,     32'h24,       5'd1, 5'd7, 32'hF000,     0, 5'd7, 32'h90));
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'hF0,       32'h0F,       32'h25,       5'd1, 5'd7, 32'hFF,       0, 5'd7, 32'h94));
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd3,        32'd5,        32'h22,       5'd1, 5'd7, 32'hFFFFFFFE, 0, 5'd7, 32'h88));
    tbl.push_back(mk(2'b10, 3'b000, 4'b0110, 32'h0,   32'd10,       32'd20,       32'h22,       5'd11,5'd7, 32'd30,       0, 5'd11,32'h88));
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd1,        32'hFFFFFFFF, 32'h2A,       5'd1, 5'd7, 32'd0,        1, 5'd7, 32'hA8));
    tbl.push_back(mk(2'b00, 3'b001, 4'b0001, 32'h4,   32'h2000,     32'hDEADBEEF, 32'd8,        5'd9, 5'd0, 32'h2008,     0, 5'd9, 32'h24));
`ifndef MULT_EN
    tbl.push_back(mk(2'b10, 3'b000, 4'b1100, 32'h0,   32'd6,        32'd7,        32'h18,       5'd1, 5'd3, 32'd0,        1, 5'd3, 32'h60));
`endif

    // ---------------- reset ----------------
    rst = 1'b1;
    drive(tbl[0]);
    #2;
    check_all_zero("reset initial");
    @(posedge clk); #1;
    check_all_zero("reset held over edge");
    rst = 1'b0;

    foreach (tbl[i]) apply_check($sformatf("vec%0d", i), tbl[i]);

    // ---------------- asynchronous reset mid-run ----------------
    apply_check("pre-arst", tbl[0]);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- randomized vs model ----------------
    fl[0] = 6'd32; fl[1] = 6'd34; fl[2] = 6'd36; fl[3] = 6'd37;
    fl[4] = 6'd42; fl[5] = 6'd7;  fl[6] = 6'd24; fl[7] = 6'd0;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] b;
      v.wb  = 2'($urandom);
      v.mem = 3'($urandom);
      v.ex  = 4'($urandom);
      f = fl[$urandom_range(0, 7)];
      if (f == 6'd0) f = 6'($urandom);
`ifdef MULT_EN
      if (v.ex[2:1] == 2'b10 && f == 6'd24) f = 6'd32;
`endif
      v.imm = {26'($urandom), f};
      v.npc = $urandom;
      v.rs  = $urandom;
      v.rtv = ($urandom_range(0, 3) == 0) ? v.rs : $urandom;
      v.rt  = 5'($urandom);
      v.rd  = 5'($urandom);
      b = v.ex[0] ? v.imm : v.rtv;
      if (v.ex[0] && $urandom_range(0, 3) == 0) v.rs = v.imm;
      v.exp_alu  = ref_alu(v.ex[2:1], f, v.rs, b);
      v.exp_zero = (v.exp_alu == 32'd0);
      v.exp_dest = v.ex[3] ? v.rd : v.rt;
      v.exp_bt   = v.npc + v.imm * 4;
      apply_check($sformatf("rand%0d", n), v);
    end

`ifdef MULT_EN
    // ---------------- multiplier sequences ----------------
    v = mk(2'b10, 3'b000, 4'b1100, 32'h0, 32'd6, 32'd7, 32'h18, 5'd1, 5'd3, 32'd0, 0, 5'd3, 32'h60);
    drive(v); #1;
    run_mult("mult 6x7", 32'd42, 2'b10, 5'd3);
    // back-to-back: next instruction is another mult, re-entered from IDLE
    v.rs = 32'd3; v.rtv = 32'hFFFFFFFF; v.rd = 5'd4;
    drive(v); #1;
    run_mult("mult b2b", 32'hFFFFFFFD, 2'b10, 5'd4);
    // reset in BUSY count 10
    v.rs = 32'd9; v.rtv = 32'd9; v.rd = 5'd5;
    drive(v);
    repeat (11) @(posedge clk);
    #3;
    check("mid-busy stall before rst", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("mult reset");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    run_mult("mult after rst", 32'd81, 2'b10, 5'd5);
    apply_check("post-mult add", tbl[0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
